// File: rtl/jk_seq_pkg.sv
// Shared types for the JK-flip-flop count sequencer: FSM states and per-bit excitation modes.
package jk_seq_pkg;

    localparam int unsigned JK_SEQ_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_UP   = 2'd2,
        MODE_DOWN = 2'd3
    } mode_t;

endpackage

// File: rtl/jk_count_sequencer_if.sv
// Command/status bundle between the lab bench (master) and the count sequencer (slave).
interface jk_count_sequencer_if
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = JK_SEQ_WIDTH
);
    logic             start;
    logic             abort;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pause, dir, load_val, limit,
        input  q, j, k, busy, done
    );

    modport slave (
        input  start, abort, pause, dir, load_val, limit,
        output q, j, k, busy, done
    );
endinterface

// File: rtl/jk_count_sequencer_jk_ff.sv
// One-bit rising-edge JK flip-flop with asynchronous active-low clear.
module jk_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic not_q
);
    logic q_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q_r <= 1'b1;
                2'b01:   q_r <= 1'b0;
                2'b11:   q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q     = q_r;
    assign not_q = ~q_r;
endmodule

// File: rtl/jk_count_sequencer.sv
// Load/count/terminate controller driving a bank of JK flip-flops; j/k are exposed combinationally.
// Optional JK_SEQ_AUTO_RELOAD_EN: DONE reloads the captured preset and loops until ABORT or reset.
module jk_count_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = JK_SEQ_WIDTH
) (
    input logic                 clk,
    input logic                 rst_n,
    jk_count_sequencer_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    mode_t            mode;
    logic             capture;
    logic             dir_r;
    logic [WIDTH-1:0] load_val_r;
    logic [WIDTH-1:0] limit_r;
    logic             busy_q;
    logic             done_q;
    logic             busy_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;

    // State, status and captured-command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dir_r      <= 1'b0;
            load_val_r <= '0;
            limit_r    <= '0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            if (capture) begin
                dir_r      <= bus.dir;
                load_val_r <= bus.load_val;
                limit_r    <= bus.limit;
            end
        end
    end

    // Next state, excitation mode and command capture
    always_comb begin
        state_nxt = state;
        mode      = MODE_HOLD;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    capture   = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mode      = MODE_LOAD;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.pause) begin
                    if (q == limit_r) begin
                        state_nxt = ST_DONE;
                    end else begin
                        mode = dir_r ? MODE_UP : MODE_DOWN;
                    end
                end
            end
            ST_DONE: begin
`ifdef JK_SEQ_AUTO_RELOAD_EN
                state_nxt = ST_LOAD;
`else
                if (bus.start) begin
                    capture   = 1'b1;
                    state_nxt = ST_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort wins over everything, including a start accepted this cycle
        if (bus.abort) begin
            state_nxt = ST_IDLE;
            mode      = MODE_HOLD;
            capture   = 1'b0;
        end

`ifdef JK_SEQ_AUTO_RELOAD_EN
        busy_nxt = (state_nxt != ST_IDLE);
`else
        busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);
`endif
        done_nxt = (state_nxt == ST_DONE);
    end

    // Toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & nq[i-1];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        case (mode)
            MODE_LOAD: begin
                j = load_val_r;
                k = ~load_val_r;
            end
            MODE_UP: begin
                j = up_t;
                k = up_t;
            end
            MODE_DOWN: begin
                j = dn_t;
                k = dn_t;
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        jk_ff u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[g]),
            .k     (k[g]),
            .q     (q[g]),
            .not_q (nq[g])
        );
    end

    assign bus.q    = q;
    assign bus.j    = j;
    assign bus.k    = k;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
